// File: rtl/mul_seq_ctrl.sv
//==============================================================================
// Module   : mul_seq_ctrl
// Brief    : Multi-cycle RV32M multiply sequencer (MUL/MULH/MULHSU/MULHU)
//            driving one shared external combinational 32-bit adder.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mul_seq_ctrl #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] add_x,
   output logic [XLEN-1:0] add_y,
   input  logic [XLEN-1:0] add_result,
   input  logic            add_overflow
);

   localparam logic [1:0]       OP_MUL    = 2'b00;
   localparam logic [1:0]       OP_MULH   = 2'b01;
   localparam logic [1:0]       OP_MULHSU = 2'b10;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(XLEN - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ITER  = 3'd1,
      S_FIXA0 = 3'd2,
      S_FIXA1 = 3'd3,
      S_FIXB0 = 3'd4,
      S_FIXB1 = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t            state_q,  state_d;
   logic [XLEN-1:0]   a_q,      a_d;
   logic [XLEN-1:0]   b_q,      b_d;
   logic [XLEN-1:0]   hi_q,     hi_d;
   logic [XLEN-1:0]   lo_q,     lo_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;
   logic [1:0]        op_q,     op_d;
   logic              a_neg_q,  a_neg_d;
   logic              b_neg_q,  b_neg_d;
   logic              done_q,   done_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              w_carry;
   logic              unused_add_overflow;

   // Carry out of HI is recovered locally, so the adder's own flag is not needed.
   assign unused_add_overflow = add_overflow;
   assign w_carry             = (add_result < add_x);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      a_neg_d  = a_neg_q;
      b_neg_d  = b_neg_q;
      done_d   = 1'b0;
      result_d = result_q;
      add_x    = '0;
      add_y    = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = rs1;
               b_d     = rs2;
               hi_d    = '0;
               lo_d    = rs2;
               cnt_d   = '0;
               op_d    = op;
               a_neg_d = rs1[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU));
               b_neg_d = rs2[XLEN-1] & (op == OP_MULH);
               state_d = S_ITER;
            end
         end

         // Shift-add step: the multiplier drains out of LO while product bits fill it.
         S_ITER: begin
            add_x = hi_q;
            add_y = lo_q[0] ? a_q : '0;
            hi_d  = {w_carry, add_result[XLEN-1:1]};
            lo_d  = {add_result[0], lo_q[XLEN-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = S_FIXA0;
            end
         end

         // Two's-complement subtract split as HI + ~X, then + 1.
         S_FIXA0: begin
            add_x   = hi_q;
            add_y   = ~(a_neg_q ? b_q : '0);
            hi_d    = add_result;
            state_d = S_FIXA1;
         end

         S_FIXA1: begin
            add_x   = hi_q;
            add_y   = XLEN'(1);
            hi_d    = add_result;
            state_d = S_FIXB0;
         end

         S_FIXB0: begin
            add_x   = hi_q;
            add_y   = ~(b_neg_q ? a_q : '0);
            hi_d    = add_result;
            state_d = S_FIXB1;
         end

         S_FIXB1: begin
            add_x   = hi_q;
            add_y   = XLEN'(1);
            hi_d    = add_result;
            state_d = S_DONE;
         end

         S_DONE: begin
            done_d   = 1'b1;
            result_d = (op_q == OP_MUL) ? lo_q : hi_q;
            state_d  = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         cnt_q    <= '0;
         op_q     <= '0;
         a_neg_q  <= 1'b0;
         b_neg_q  <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         a_neg_q  <= a_neg_d;
         b_neg_q  <= b_neg_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
//==============================================================================
// Module   : tb_mul_seq_ctrl
// Brief    : Self-checking bench for mul_seq_ctrl against a 64-bit product model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mul_seq_ctrl;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op    = 2'b00;
   logic [31:0] rs1   = '0;
   logic [31:0] rs2   = '0;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [31:0] add_x;
   logic [31:0] add_y;
   logic [31:0] add_result;
   logic        add_overflow;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // Stand-in for the shared adder32.
   assign add_result   = add_x + add_y;
   assign add_overflow = (add_x[31] == add_y[31]) && (add_result[31] != add_x[31]);

   mul_seq_ctrl #(.XLEN(32), .CNT_W(5)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .op           (op),
      .rs1          (rs1),
      .rs2          (rs2),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .add_x        (add_x),
      .add_y        (add_y),
      .add_result   (add_result),
      .add_overflow (add_overflow)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Product of the operands as sign/zero-extended 64-bit values.
   function automatic logic [31:0] ref_mul(input logic [1:0] f_op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [63:0] ea;
      logic [63:0] eb;
      logic [63:0] p;
      ea = (f_op == 2'b01 || f_op == 2'b10) ? {{32{a[31]}}, a} : {32'h0, a};
      eb = (f_op == 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
      p  = ea * eb;
      return (f_op == 2'b00) ? p[31:0] : p[63:32];
   endfunction

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'h0000_0000;
         1:       return 32'h0000_0001;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // Called at #1 after a rising edge; the request is sampled on the next edge.
   task automatic launch(input logic [1:0] l_op, input logic [31:0] a, input logic [31:0] b);
      op    = l_op;
      rs1   = a;
      rs2   = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 2'($urandom);
      rs1   = $urandom;
      rs2   = $urandom;
   endtask

   task automatic wait_done(input string tag, input logic [31:0] exp, input bit noise);
      int cyc  = 0;
      bit seen = 1'b0;
      while (!seen && cyc < 80) begin
         @(posedge clk);
         #1;
         cyc++;
         if (noise && cyc == 10) start = 1'b1;
         if (noise && cyc == 11) start = 1'b0;
         if (noise && cyc == 36) begin
            check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
            start = 1'b1;
         end
         if (done) seen = 1'b1;
      end
      start = 1'b0;
      check({tag, "_timeout"}, 32'(seen), 32'd1);
      check({tag, "_latency"}, 32'(cyc), 32'd37);
      check({tag, "_result"}, result, exp);
   endtask

   task automatic finish_op(input string tag, input logic [31:0] exp);
      @(posedge clk);
      #1;
      check({tag, "_done_single"}, 32'(done), 32'd0);
      check({tag, "_idle"}, 32'(busy), 32'd0);
      check({tag, "_held"}, result, exp);
      check({tag, "_addx_idle"}, add_x, 32'd0);
      check({tag, "_addy_idle"}, add_y, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [1:0] r_op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit noise);
      launch(r_op, a, b);
      wait_done(tag, exp, noise);
      finish_op(tag, exp);
   endtask

   initial begin
      logic [1:0]  r_op;
      logic [31:0] ra;
      logic [31:0] rb;
      logic [31:0] exp2;

      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_addx", add_x, 32'd0);
      check("rst_addy", add_y, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_op("mul_3x5",       2'b00, 32'd3,         32'd5,         32'h0000_000F, 1'b0);
      run_op("mulhu_ff",      2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      run_op("mul_ff",        2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
      run_op("mulh_ff",       2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
      run_op("mulh_min",      2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
      run_op("mulhsu_neg",    2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
      run_op("mulhu_carry",   2'b11, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 1'b0);

      ra = 32'hDEAD_BEEF;
      rb = 32'h8765_4321;
      run_op("mulh_noise", 2'b01, ra, rb, ref_mul(2'b01, ra, rb), 1'b1);

      ra   = $urandom;
      rb   = $urandom;
      exp2 = ref_mul(2'b10, rb, ra);
      launch(2'b11, ra, rb);
      wait_done("b2b_first", ref_mul(2'b11, ra, rb), 1'b0);
      launch(2'b10, rb, ra);
      wait_done("b2b_second", exp2, 1'b0);
      finish_op("b2b_second", exp2);

      for (int i = 0; i < 20; i++) begin
         r_op = 2'($urandom_range(0, 3));
         ra   = pick_operand();
         rb   = pick_operand();
         run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, ra, rb, ref_mul(r_op, ra, rb), 1'b0);
      end

      run_op("pre_reset", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      launch(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op("post_rst_7x6", 2'b00, 32'd7, 32'd6, 32'h0000_002A, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
